// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-outstanding memory backend.
// Round-robin on ties, one command in flight, combinational ready and read-valid.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        inst_start,
  output logic        inst_ready,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_valid,
  // data port
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  // backend port
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} state_t;
  typedef enum logic {INST, DATA} port_t;

  state_t      state, state_nxt;
  port_t       owner, last_grant;
  logic        write_q;
  logic [31:0] addr_q, wdata_q, wmask_q;

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    inst_ready    = 1'b0;
    d_cmd_ready   = 1'b0;
    inst_valid    = 1'b0;
    d_rdata_valid = 1'b0;
    mem_cmd_start = 1'b0;
    case (state)
      IDLE: begin
        if (inst_start && d_cmd_start) begin
          // round-robin: the port that did not win last time takes the tie
          if (last_grant == INST) d_cmd_ready = 1'b1;
          else                    inst_ready  = 1'b1;
        end else begin
          inst_ready  = inst_start;
          d_cmd_ready = d_cmd_start;
        end
        if (inst_start || d_cmd_start) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_cmd_start = 1'b1;
        if (mem_cmd_ready) state_nxt = write_q ? IDLE : WAIT_R;
      end
      WAIT_R: begin
        if (mem_rdata_valid) begin
          inst_valid    = (owner == INST);
          d_rdata_valid = (owner == DATA);
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= INST;
      last_grant <= INST;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state <= state_nxt;
      if (inst_ready) begin
        owner      <= INST;
        last_grant <= INST;
        write_q    <= 1'b0;
        addr_q     <= inst_addr;
        wdata_q    <= '0;
        wmask_q    <= '0;
      end else if (d_cmd_ready) begin
        owner      <= DATA;
        last_grant <= DATA;
        write_q    <= d_cmd_write;
        addr_q     <= d_addr;
        wdata_q    <= d_wdata;
        wmask_q    <= d_wmask;
      end
    end
  end

  assign mem_cmd_write = write_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign inst_rdata    = mem_rdata;
  assign d_rdata       = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// stall/reset sequences, then random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_start, inst_ready, inst_valid;
  logic [31:0] inst_addr, inst_rdata;
  logic        d_cmd_start, d_cmd_write, d_cmd_ready, d_rdata_valid;
  logic [31:0] d_addr, d_wdata, d_wmask, d_rdata;
  logic        mem_cmd_start, mem_cmd_write, mem_cmd_ready, mem_rdata_valid;
  logic [31:0] mem_addr, mem_wdata, mem_wmask, mem_rdata;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_start(inst_start), .inst_ready(inst_ready), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .d_cmd_start(d_cmd_start), .d_cmd_write(d_cmd_write), .d_cmd_ready(d_cmd_ready),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_ready(mem_cmd_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, is;
    logic [31:0] ia;
    logic        ds, dw;
    logic [31:0] da, dwd, dm;
    logic        mr, mv;
    logic [31:0] md;
  } stim_t;

  typedef struct {
    logic        ir, dr, ms, mw;
    logic [31:0] ma;
    logic        iv, dv;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    bit is_data;
    bit is_write;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // well before the next rising edge.
  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.rst; inst_start = s.is; inst_addr = s.ia;
    d_cmd_start = s.ds; d_cmd_write = s.dw; d_addr = s.da; d_wdata = s.dwd; d_wmask = s.dm;
    mem_cmd_ready = s.mr; mem_rdata_valid = s.mv; mem_rdata = s.md;
    #1;
  endtask

  task automatic check_exp(input string tag, input exp_t e, input logic [31:0] md);
    check({tag, " inst_ready"},    {31'd0, inst_ready},    {31'd0, e.ir});
    check({tag, " d_cmd_ready"},   {31'd0, d_cmd_ready},   {31'd0, e.dr});
    check({tag, " mem_cmd_start"}, {31'd0, mem_cmd_start}, {31'd0, e.ms});
    check({tag, " mem_cmd_write"}, {31'd0, mem_cmd_write}, {31'd0, e.mw});
    check({tag, " mem_addr"},      mem_addr,               e.ma);
    check({tag, " inst_valid"},    {31'd0, inst_valid},    {31'd0, e.iv});
    check({tag, " d_rdata_valid"}, {31'd0, d_rdata_valid}, {31'd0, e.dv});
    if (e.iv) check({tag, " inst_rdata"}, inst_rdata, md);
    if (e.dv) check({tag, " d_rdata"},    d_rdata,    md);
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst:1'b0, is:1'b0, ia:32'd0, ds:1'b0, dw:1'b0, da:32'd0,
          dwd:32'd0, dm:32'd0, mr:1'b0, mv:1'b0, md:32'd0};
    return s;
  endfunction

  vec_t tbl [17];

  // transaction-level reference model state
  txn_t        pend[$];
  bit          sent, last_data;
  bit          lat_write;
  logic [31:0] lat_addr, lat_wdata, lat_wmask;

  initial begin
    stim_t s;
    exp_t  e;

    // rows: {rst,is,ia,ds,dw,da,dwd,dm,mr,mv,md} -> {ir,dr,ms,mw,ma,iv,dv}
    tbl[0]  = '{'{0,1,32'h100,0,0,0,0,0,0,0,0},                     '{1,0,0,0,32'h0,0,0}};
    tbl[1]  = '{'{0,0,0,0,0,0,0,0,1,0,0},                           '{0,0,1,0,32'h100,0,0}};
    tbl[2]  = '{'{0,0,0,0,0,0,0,0,0,1,32'h13},                      '{0,0,0,0,32'h100,1,0}};
    tbl[3]  = '{'{1,0,0,0,0,0,0,0,0,0,0},                           '{0,0,0,0,32'h100,0,0}};
    tbl[4]  = '{'{0,1,32'h200,1,0,32'h300,0,0,0,0,0},               '{0,1,0,0,32'h0,0,0}};
    tbl[5]  = '{'{0,1,32'h200,1,0,32'h300,0,0,1,0,0},               '{0,0,1,0,32'h300,0,0}};
    tbl[6]  = '{'{0,1,32'h200,1,0,32'h300,0,0,0,1,32'hAAAA5555},    '{0,0,0,0,32'h300,0,1}};
    tbl[7]  = '{'{0,1,32'h200,1,0,32'h300,0,0,0,0,0},               '{1,0,0,0,32'h300,0,0}};
    tbl[8]  = '{'{0,0,0,1,0,32'h300,0,0,0,1,32'hEEEE},              '{0,0,1,0,32'h200,0,0}};
    tbl[9]  = '{'{0,0,0,1,0,32'h300,0,0,1,0,0},                     '{0,0,1,0,32'h200,0,0}};
    tbl[10] = '{'{0,1,32'h200,1,1,32'h300,32'h12345678,32'hFF,0,1,32'h0BADF00D}, '{0,0,0,0,32'h200,1,0}};
    tbl[11] = '{'{0,1,32'h200,1,1,32'h300,32'h12345678,32'hFF,0,0,0},           '{0,1,0,0,32'h200,0,0}};
    tbl[12] = '{'{0,0,0,0,0,0,0,0,1,1,32'h1111},                    '{0,0,1,1,32'h300,0,0}};
    tbl[13] = '{'{0,0,0,0,0,0,0,0,0,1,32'h2222},                    '{0,0,0,1,32'h300,0,0}};
    tbl[14] = '{'{0,1,32'h400,0,0,0,0,0,0,0,0},                     '{1,0,0,1,32'h300,0,0}};
    tbl[15] = '{'{0,0,0,0,0,0,0,0,1,0,0},                           '{0,0,1,0,32'h400,0,0}};
    tbl[16] = '{'{0,0,0,0,0,0,0,0,0,1,32'h77},                      '{0,0,0,0,32'h400,1,0}};

    // reset: held for a few edges, outputs quiet while asserted
    s = idle_stim();
    s.rst = 1'b1;
    drive(s);
    drive(s);
    drive(s);
    check("reset mem_cmd_start", {31'd0, mem_cmd_start}, 32'd0);
    check("reset inst_valid",    {31'd0, inst_valid},    32'd0);
    check("reset d_rdata_valid", {31'd0, d_rdata_valid}, 32'd0);
    check("reset mem_addr",      mem_addr,               32'd0);
    check("reset mem_wmask",     mem_wmask,              32'd0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].s);
      check_exp($sformatf("vec%0d", i), tbl[i].e, tbl[i].s.md);
    end

    // data write with the backend stalling three cycles
    s = idle_stim();
    s.ds = 1'b1; s.dw = 1'b1; s.da = 32'h2000; s.dwd = 32'hDEADBEEF; s.dm = 32'h0000FFFF;
    drive(s);
    check("wr accept d_cmd_ready", {31'd0, d_cmd_ready}, 32'd1);
    s.ds = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s.mr = (c == 3);
      drive(s);
      check($sformatf("wr c%0d mem_cmd_start", c), {31'd0, mem_cmd_start}, 32'd1);
      check($sformatf("wr c%0d mem_cmd_write", c), {31'd0, mem_cmd_write}, 32'd1);
      check($sformatf("wr c%0d mem_addr", c),      mem_addr,  32'h2000);
      check($sformatf("wr c%0d mem_wdata", c),     mem_wdata, 32'hDEADBEEF);
      check($sformatf("wr c%0d mem_wmask", c),     mem_wmask, 32'h0000FFFF);
      check($sformatf("wr c%0d valids", c), {30'd0, inst_valid, d_rdata_valid}, 32'd0);
    end
    s = idle_stim();
    s.mv = 1'b1;
    drive(s);
    check("wr done mem_cmd_start", {31'd0, mem_cmd_start}, 32'd0);
    check("wr done valids", {30'd0, inst_valid, d_rdata_valid}, 32'd0);

    // reset while a data read waits for its response, then a late strobe
    s = idle_stim();
    s.ds = 1'b1; s.da = 32'h3000;
    drive(s);
    check("rd accept d_cmd_ready", {31'd0, d_cmd_ready}, 32'd1);
    s = idle_stim();
    s.mr = 1'b1;
    drive(s);
    check("rd issue mem_addr", mem_addr, 32'h3000);
    s = idle_stim();
    s.rst = 1'b1;
    drive(s);
    check("rd wait mem_cmd_start", {31'd0, mem_cmd_start}, 32'd0);
    s = idle_stim();
    s.mv = 1'b1; s.md = 32'h55;
    drive(s);
    check("late strobe d_rdata_valid", {31'd0, d_rdata_valid}, 32'd0);
    check("late strobe inst_valid",    {31'd0, inst_valid},    32'd0);
    check("post reset mem_addr",       mem_addr,               32'd0);
    s = idle_stim();
    s.is = 1'b1; s.ia = 32'h500;
    drive(s);
    check("post reset inst_ready", {31'd0, inst_ready}, 32'd1);
    s = idle_stim();
    drive(s);
    check("post reset issue", {31'd0, mem_cmd_start}, 32'd1);
    check("post reset addr",  mem_addr, 32'h500);

    // random traffic against the model, starting from a clean reset
    s = idle_stim();
    s.rst = 1'b1;
    drive(s);
    pend.delete();
    sent = 0; last_data = 0; lat_write = 0;
    lat_addr = '0; lat_wdata = '0; lat_wmask = '0;
    for (int n = 0; n < 3000; n++) begin
      bit idle, acc_i, acc_d;
      s.rst = ($urandom_range(0, 63) == 0);
      s.is  = $urandom_range(0, 1);
      s.ds  = $urandom_range(0, 1);
      s.dw  = $urandom_range(0, 1);
      s.ia  = $urandom; s.da = $urandom; s.dwd = $urandom; s.dm = $urandom;
      s.mr  = $urandom_range(0, 1);
      s.mv  = ($urandom_range(0, 2) == 0);
      s.md  = $urandom;
      drive(s);

      idle  = (pend.size() == 0);
      acc_i = idle && s.is && (!s.ds || last_data);
      acc_d = idle && s.ds && (!s.is || !last_data);
      e.ir = acc_i;
      e.dr = acc_d;
      e.ms = !idle && !sent;
      e.mw = lat_write;
      e.ma = lat_addr;
      e.iv = !idle && sent && s.mv && !pend[0].is_data;
      e.dv = !idle && sent && s.mv &&  pend[0].is_data;
      check_exp("rand", e, s.md);
      check("rand mem_wdata", mem_wdata, lat_wdata);
      check("rand mem_wmask", mem_wmask, lat_wmask);

      if (s.rst) begin
        pend.delete();
        sent = 0; last_data = 0; lat_write = 0;
        lat_addr = '0; lat_wdata = '0; lat_wmask = '0;
      end else if (acc_i) begin
        pend.push_back('{is_data:1'b0, is_write:1'b0});
        last_data = 0; sent = 0;
        lat_write = 0; lat_addr = s.ia; lat_wdata = '0; lat_wmask = '0;
      end else if (acc_d) begin
        pend.push_back('{is_data:1'b1, is_write:s.dw});
        last_data = 1; sent = 0;
        lat_write = s.dw; lat_addr = s.da; lat_wdata = s.dwd; lat_wmask = s.dm;
      end else if (!idle && !sent && s.mr) begin
        if (pend[0].is_write) void'(pend.pop_front());
        else                  sent = 1;
      end else if (!idle && sent && s.mv) begin
        void'(pend.pop_front());
        sent = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
